// File: rtl/sig_splice_pkg.sv
// Shared definitions for the nibble splice / unsplice pair: phase encoding,
// half-word width helper and the error-counter ceiling.
package sig_splice_pkg;

  // Which half of the channel words the next spliced beat carries.
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

  // Default full word width per channel.
  localparam int W_DEFAULT = 8;

  // Half-word width for a given full word width (word width must be even).
  function automatic int half_of(input int w);
    return w / 2;
  endfunction

  // Realignment counter ceiling; the counter sticks here.
  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/sig_unsplice_oreg.sv
// Single-entry valid/ready output register. The owner loads a new entry only
// when load_ready is high; a load and an output handshake may coincide.
module sig_unsplice_oreg
  import sig_splice_pkg::*;
#(
  parameter int DW = 2 * W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic          load_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout
);

  logic          valid_reg;
  logic [DW-1:0] data_reg;

  // Space exists when empty or when the current entry leaves this cycle.
  assign load_ready = !valid_reg | out_ready;
  assign out_valid  = valid_reg;
  assign dout       = data_reg;

  // Hold the pair until taken; a same-cycle load replaces it and keeps valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= din;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/sig_unsplice.sv
// Receive-side unsplicer: rebuilds one word per channel from a low-half beat
// followed by a high-half beat, with sync-driven realignment and a registered,
// backpressured output pair.
module sig_unsplice
  import sig_splice_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sync,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [15:0]  word_cnt,
  output logic [7:0]   err_cnt
);

  localparam int HALF = half_of(W);

  phase_t            state_reg;
  logic [HALF-1:0]   lo_reg [2];
  logic [15:0]       word_cnt_reg;
  logic [7:0]        err_cnt_reg;

  logic              oreg_ready;
  logic              accept;
  logic              hi_done;
  logic [HALF-1:0]   beat_half [2];
  logic [W-1:0]      word_next [2];
  logic [2*W-1:0]    pair_out;

  // LO never waits on the output; HI can only finish into a free output slot.
  assign in_ready = (state_reg == PH_LO) ? 1'b1 : oreg_ready;
  assign accept   = in_valid & in_ready;
  assign hi_done  = accept & (state_reg == PH_HI) & !in_sync;

  // Channel 0 rides in the upper half of the beat, channel 1 in the lower.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    assign beat_half[gi] = in_data[W-1-gi*HALF -: HALF];
    assign word_next[gi] = {beat_half[gi], lo_reg[gi]};
  end

  // Phase FSM with held low halves and the pair / realignment counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= PH_LO;
      for (int i = 0; i < 2; i++) lo_reg[i] <= '0;
      word_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else if (accept) begin
      case (state_reg)
        PH_LO: begin
          for (int i = 0; i < 2; i++) lo_reg[i] <= beat_half[i];
          state_reg <= PH_HI;
        end
        PH_HI: begin
          if (in_sync) begin
            // Sync in HI means the held lows were orphaned: restart the word.
            for (int i = 0; i < 2; i++) lo_reg[i] <= beat_half[i];
            if (err_cnt_reg != ERR_MAX) err_cnt_reg <= err_cnt_reg + 8'd1;
          end else begin
            word_cnt_reg <= word_cnt_reg + 16'd1;
            state_reg    <= PH_LO;
          end
        end
        default: state_reg <= PH_LO;
      endcase
    end
  end

  sig_unsplice_oreg #(
    .DW(2 * W)
  ) u_oreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hi_done),
    .din        ({word_next[0], word_next[1]}),
    .load_ready (oreg_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (pair_out)
  );

  assign o0       = pair_out[2*W-1:W];
  assign o1       = pair_out[W-1:0];
  assign word_cnt = word_cnt_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: doc/sig_unsplice.md
# sig_unsplice

Receive-side counterpart of the nibble splice path. Consumes a stream of spliced bytes, each carrying one half-word of channel 0 in the upper half and one half-word of channel 1 in the lower half. Reassembles two full words per channel-pair over two accepted beats, low halves first, then high halves. Sits between the spliced link and the two word-wide consumers, with a registered, backpressured output and sync-based realignment.

## Interface
Parameters:
- W, default 8: full word width per channel; must be even; HALF = W/2.

Ports:
- clk  in  1  rising-edge clock; only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  spliced beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  W  spliced beat; in_data[W-1:HALF] is the channel-0 half, in_data[HALF-1:0] is the channel-1 half.
- in_sync  in  1  sideband, qualified by in_valid; marks the beat as a low-half beat (start of word).
- out_valid  out  1  o0/o1 hold a reassembled pair.
- out_ready  in  1  consumer takes the pair.
- o0  out  W  channel-0 word {hi0, lo0}.
- o1  out  W  channel-1 word {hi1, lo1}.
- word_cnt  out  16  pairs emitted; wraps modulo 2^16.
- err_cnt  out  8  realignment events; saturates at 255.

## Operation
- Beat accepted = in_valid & in_ready.
- Phase FSM has two states:
  - LO (reset): expects low halves.
  - HI: expects high halves.
- In LO:
  - in_ready = 1.
  - On an accepted beat: lo0 <= in_data[W-1:HALF], lo1 <= in_data[HALF-1:0], go to HI.
  - in_sync is ignored in LO because the beat is already a low beat.
- In HI:
  - in_ready = !out_valid | out_ready.
  - If the accepted beat has in_sync = 0: o0 <= {in_data[W-1:HALF], lo0}, o1 <= {in_data[HALF-1:0], lo1}, out_valid <= 1, word_cnt += 1, go to LO.
  - If the accepted beat has in_sync = 1: discard the held low halves and treat the beat as a new low beat (reload lo0/lo1, stay in HI). err_cnt increments, saturating. No output is produced.
- Output register:
  - out_valid clears on out_ready when no new pair is loaded in the same cycle.
  - o0/o1 are stable while out_valid & !out_ready.
- Simultaneous events:
  - Output handshake and completing HI beat in the same cycle: the new pair loads and out_valid stays 1.
  - A sync beat in HI while the output is stalled is not accepted, because in_ready = 0.
- Reset values:
  - state = LO, out_valid = 0, o0 = o1 = 0, lo0 = lo1 = 0, word_cnt = 0, err_cnt = 0.
  - in_ready = 1, combinational from the LO state.
- Reset asserted mid-word drops any held low halves and any pending output pair. Nothing is flushed.

## Timing
- Latency: out_valid rises the cycle after the HI beat is accepted.
- Sustained throughput is one pair every 2 cycles with out_ready held high.
- in_ready depends combinationally on state, out_valid and out_ready only. It never depends on in_valid.
- No combinational path from in_data to o0 or o1.
- word_cnt and err_cnt update on the same edge as the event that changes them.

## Structure
- Shared package sig_splice_pkg holds:
  - the phase enum (PH_LO, PH_HI);
  - localparam helpers for HALF;
  - ERR_MAX = 8'hFF.
  - The splice-side transmitter uses the same package.
- Sub-module sig_unsplice_oreg: a single-entry valid/ready output register (2W data bits). It exposes load/ready to the FSM.
- Counters and FSM stay in the top module.

## Test plan
- Basic pair: beats 8'h3C (sync=1) then 8'hA5, out_ready = 1 → next cycle out_valid = 1, o0 = 8'hA3, o1 = 8'h5C, word_cnt = 1.
- Backpressure:
  - Setup: out_ready = 0 after the first pair is emitted.
  - Stimulus: send beats 8'h12 then 8'h34.
  - Required: the LO beat is accepted; in_ready = 0 in HI; o0/o1 hold 8'hA3/8'h5C.
  - On out_ready = 1: the HI beat is accepted the same cycle and o0 = 8'h31, o1 = 8'h42 appear on the next cycle.
- Realign: send 8'h11 (sync), then 8'h22 with sync=1, then 8'h33 → err_cnt = 1, o0 = 8'h32, o1 = 8'h32; 8'h11 never appears on the outputs.
- Streaming: 512 back-to-back beats with out_ready = 1 → 256 pairs, one every 2 cycles; word_cnt = 256; err_cnt = 0.
- Reset mid-word:
  - Stimulus: accept a LO beat, pulse rst_n = 0 for 1 cycle, then send 8'hF0 and 8'h0F.
  - Required: o0 = 8'h0F, o1 = 8'hF0, word_cnt = 1.
- Saturation: force 300 sync-in-HI events → err_cnt holds at 255; word_cnt wraps from 16'hFFFF to 0.
